// File: rtl/mips32_boot_loader.sv
// mips32_boot_loader
//
// Receives a framed program image over a valid/ready byte stream and writes it
// into the mips32 instruction memory. The core is released only after the
// whole frame has loaded and its XOR checksum matches.
//
// Frame: [count N][4N data bytes, big-endian words][checksum = XOR of data]
//
// Ports
//   clock, reset_n          single rising-edge clock, synchronous active-low reset
//   in_valid/in_data        upstream byte stream
//   in_ready                byte accepted on edges where in_valid && in_ready
//   imem_we/addr/wdata      registered one-cycle instruction-memory write
//   cpu_run                 high lets the core run
//   done                    sticky: load completed with a good checksum
//   error                   sticky: frame rejected (bad count or checksum)
module mips32_boot_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  localparam int CW    = ADDR_W + 1;  // one extra bit so N == DEPTH never wraps
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CW-1:0] ONE_W = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [23:0]         asm_q, asm_d;   // first three bytes of the word in flight
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                err_q, err_d;

  logic                accept;
  logic [31:0]         n_ext;

  assign accept = in_valid && in_ready_q;
  assign n_ext  = {24'd0, in_data};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (n_ext == 32'd0 || n_ext > 32'(DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            cnt_d      = CW'(in_data);
            word_idx_d = '0;
            byte_idx_d = '0;
            xor_d      = '0;
            asm_d      = '0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data;
          asm_d      = {asm_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q[ADDR_W-1:0];
            wdata_d    = {asm_q, in_data};
            word_idx_d = word_idx_q + ONE_W;
            if (word_idx_q + ONE_W == cnt_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (in_data == xor_q) ? S_RUN : S_ERROR;
      end
      default: ;  // RUN and ERROR are terminal until reset
    endcase

    // Outputs are registered from the next state so they change the cycle
    // after the deciding byte is accepted.
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_CHECK);
    run_d      = (state_d == S_RUN);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      asm_q      <= asm_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign done       = run_q;
  assign error      = err_q;

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Testbench for mips32_boot_loader: a per-cycle vector table for the short
// frames (good/bad checksum, illegal counts, boundary count) followed by
// hand-written sequences for a full 32-word load with random gaps, a reset
// mid-frame, and input activity while running.
module tb_mips32_boot_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;

  mips32_boot_loader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        chk_aw;   // compare addr/wdata on this row
    logic        run;
    logic        dn;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  int          tests = 0;
  int          fails = 0;

  // write log, filled by tick()
  logic [4:0]  wr_addr[64];
  logic [31:0] wr_data[64];
  int          wr_n = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (imem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
    end
  endtask

  task automatic row(input logic rst_n, input logic vld, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [4:0] addr,
                     input logic [31:0] wdata, input logic chk_aw,
                     input logic run, input logic dn, input logic err);
    vec_t v;
    v = '{rst_n, vld, d, rdy, we, addr, wdata, chk_aw, run, dn, err};
    vecs.push_back(v);
  endtask

  task automatic rst_row();
    row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // N=2 frame 0x20010005, 0x00221820 with one mid-word gap; XOR of the eight
  // data bytes is 0x3E, so cs==0x3E is good and anything else is rejected.
  task automatic frame_rows(input logic [7:0] cs, input logic good);
    rst_row();
    row(1, 1, 8'h02, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h20, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h01, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 8'hAA, 1, 0, 0, 0, 0, 0, 0, 0);  // gap, data must be ignored
    row(1, 1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h05, 1, 1, 5'd0, 32'h20010005, 1, 0, 0, 0);
    row(1, 1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h22, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h18, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h20, 1, 1, 5'd1, 32'h00221820, 1, 0, 0, 0);
    row(1, 1, cs,    0, 0, 0, 0, 0, good, good, !good);
    row(1, 1, 8'h00, 0, 0, 0, 0, 0, good, good, !good);
    row(1, 0, 8'h00, 0, 0, 0, 0, 0, good, good, !good);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n  = 1'b1;
  endtask

  initial begin
    logic [31:0] words[32];
    logic [7:0]  cs;
    int          bad;
    int          wr_before;

    // ---------------- table-driven vectors ----------------
    frame_rows(8'h3E, 1'b1);
    frame_rows(8'h07, 1'b0);
    // count 0 is illegal
    rst_row();
    row(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    row(1, 1, 8'h05, 0, 0, 0, 0, 0, 0, 0, 1);
    // count 33 exceeds DEPTH
    rst_row();
    row(1, 1, 8'h21, 0, 0, 0, 0, 0, 0, 0, 1);
    row(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    // count 32 == DEPTH is legal
    rst_row();
    row(1, 1, 8'h20, 1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 8'h12, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset_n  = vecs[i].rst_n;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].d;
      tick();
      tests++;
      if (in_ready !== vecs[i].rdy || imem_we !== vecs[i].we ||
          cpu_run !== vecs[i].run || done !== vecs[i].dn || error !== vecs[i].err ||
          (vecs[i].chk_aw && (imem_addr !== vecs[i].addr || imem_wdata !== vecs[i].wdata))) begin
        fails++;
        $display("FAIL vec%0d: got rdy=%b we=%b addr=%0d wdata=%08h run=%b done=%b err=%b want rdy=%b we=%b addr=%0d wdata=%08h run=%b done=%b err=%b",
                 i, in_ready, imem_we, imem_addr, imem_wdata, cpu_run, done, error,
                 vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].run, vecs[i].dn, vecs[i].err);
      end
    end
    in_valid = 1'b0;

    // ---------------- N=32, random data and gaps ----------------
    do_reset();
    wr_n = 0;
    cs   = 8'h00;
    for (int k = 0; k < 32; k++) begin
      words[k] = $urandom;
      cs = cs ^ words[k][31:24] ^ words[k][23:16] ^ words[k][15:8] ^ words[k][7:0];
    end
    send_byte(8'd32);
    for (int k = 0; k < 32; k++) begin
      send_byte(words[k][31:24]);
      send_byte(words[k][23:16]);
      send_byte(words[k][15:8]);
      send_byte(words[k][7:0]);
    end
    send_byte(cs);
    check_eq("n32_done", {31'd0, done}, 32'd1);
    check_eq("n32_run", {31'd0, cpu_run}, 32'd1);
    check_eq("n32_err", {31'd0, error}, 32'd0);
    check_eq("n32_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) tick();
    check_eq("n32_wr_count", wr_n, 32);
    bad = 0;
    for (int k = 0; k < 32 && k < wr_n; k++)
      if (wr_addr[k] !== 5'(k) || wr_data[k] !== words[k]) bad++;
    check_eq("n32_wr_content", bad, 0);
    check_eq("n32_last_addr", {27'd0, wr_addr[31]}, 32'd31);

    // ---------------- reset mid-frame, then N=1 ----------------
    do_reset();
    wr_n = 0;
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00);
    check_eq("mid_first_write", wr_n, 1);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    tick();
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_we", {31'd0, imem_we}, 32'd0);
    check_eq("rst_addr", {27'd0, imem_addr}, 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_flags", {29'd0, cpu_run, done, error}, 32'd0);
    reset_n = 1'b1;
    wr_n = 0;
    send_byte(8'h01);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00);
    check_eq("n1_wr_count", wr_n, 1);
    check_eq("n1_wr_addr", {27'd0, wr_addr[0]}, 32'd0);
    check_eq("n1_wr_data", wr_data[0], 32'hFFFFFFFF);
    check_eq("n1_done", {31'd0, done}, 32'd1);

    // ---------------- input activity while running ----------------
    wr_before = wr_n;
    bad = 0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (10) begin
      tick();
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || cpu_run !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check_eq("run_hold", bad, 0);
    check_eq("run_no_write", wr_n, wr_before);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
